sha256_chain_core: RTL and testbench
====================================

Name: sha256_chain_core

Overview:
- Parametrised, iterative SHA-256 compression engine and next generation of the single-block core.
- Accepts pre-padded 512-bit blocks and chains intermediate hash state across blocks, so messages of any length are supported.
- Executes ROUNDS_PER_CYCLE rounds per clock.
- Sits between the fsb-side assembler and the output channel, using a valid/ready input and valid/yumi output handshake.

Parameters:
- ROUNDS_PER_CYCLE, 1: rounds unrolled per clock; legal values 1, 2, 4, 8; other values are an elaboration error.
- COUNT_W, 16: width of the per-message block counter.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset; deassertion is synchronous to clk_i.
- en_i  in  1  enable; low freezes all internal state.
- v_i  in  1  block_i, first_i and last_i are valid.
- ready_o  out  1  core can accept a block this cycle.
- block_i  in  512  padded block; W0 in [511:480], W15 in [31:0].
- first_i  in  1  block is the first block of a message.
- last_i  in  1  block is the last block of a message.
- v_o  out  1  digest_o is valid.
- yumi_i  in  1  consumer takes the digest; legal only while v_o=1.
- digest_o  out  256  final hash; H0 in [255:224], H7 in [31:0].
- block_cnt_o  out  COUNT_W  blocks absorbed into the current message.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - state=eIdle; ready_o=0 while in reset; v_o=0; digest_o=0; block_cnt_o=0.
  - H registers = SHA-256 IV; chain_valid=0; round counter=0.
  - Reset asserted mid-operation aborts immediately; no partial digest is ever emitted.
- ready_o = (state==eIdle) & en_i & reset_n_i. Acceptance occurs when v_i & ready_o are both high at a rising edge.
- State machine:
  - eIdle -> eBusy on acceptance:
    - if first_i=1 or chain_valid=0, H and working vars a..h load from the IV and block_cnt_o=1;
    - otherwise a..h load from the chained H and block_cnt_o increments, saturating at all-ones.
    - W window loads from block_i; round counter=0.
  - eBusy: each enabled edge performs ROUNDS_PER_CYCLE rounds (Kt from the round-constant table, Wt from the 16-word sliding schedule) and advances the counter by ROUNDS_PER_CYCLE. After 64/ROUNDS_PER_CYCLE edges -> eFold.
  - eFold, one edge: H_i <= H_i + working_i, each word mod 2^32.
    - if the latched last flag = 1: digest_o <= the new H, v_o <= 1, chain_valid <= 0, -> eDone;
    - otherwise chain_valid <= 1, -> eIdle.
  - eDone: digest_o and v_o hold until yumi_i=1. On that edge v_o <= 0 and -> eIdle. digest_o retains its value after the handshake.
- Latency: v_o rises 64/ROUNDS_PER_CYCLE+1 enabled cycles after the accepting edge (65 for R=1, 9 for R=8).
- Per-block throughput: 64/R+1 cycles, plus 1 idle cycle.
- en_i=0:
  - freezes state, round counter, W window and H;
  - in eDone, v_o stays asserted and yumi_i is still honoured.
- Boundary conditions:
  - first_i=1 while a chain is open: the open message is abandoned silently and restarts from the IV.
  - first_i=0 with no open chain (after reset or after a last block): the block is hashed from the IV as a new message.
  - first_i=1 and last_i=1 together: single-block message.
  - v_i while ready_o=0: ignored; the upstream holds its data.
  - yumi_i=0 while v_o=0: no effect.

Optional Feature:
- SHA256_SHA224_MODE_EN: adds input port mode224_i (1 bit), sampled with first-block acceptance.
  - When mode224_i=1, the IV is the SHA-224 IV. digest_o[255:32] carries H0..H6 and digest_o[31:0]=0.
  - When mode224_i=0, or when the macro is undefined (no port), behaviour is SHA-256 only.

Test Plan:
- Reset with reset_n_i=0 mid-eBusy, then release -> v_o=0, ready_o=1 on the next cycle, block_cnt_o=0, no digest produced.
- Padded "abc", first_i=last_i=1, R=1 -> v_o exactly 65 cycles after acceptance; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first then last -> single v_o pulse; digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; block_cnt_o=2.
- R=8 "abc" with yumi_i held low 20 cycles -> v_o 9 cycles after acceptance; digest stable; ready_o=0 until the yumi edge.
- en_i toggled pseudo-randomly during "abc" -> same digest, with latency extended by the number of disabled cycles.
- Open chain, then a block with first_i=1 -> result equals a fresh single-block hash; with SHA256_SHA224_MODE_EN and mode224_i=1 on "abc", digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.

Source files
------------

// File: rtl/sha256_chain_core.sv
// Iterative SHA-256 compression engine with multi-block hash chaining and a
// valid/ready input, valid/yumi output. Define SHA256_SHA224_MODE_EN for SHA-224 support.
module sha256_chain_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int COUNT_W          = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [511:0]       block_i,
    input  logic               first_i,
    input  logic               last_i,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [255:0]       digest_o,
`ifdef SHA256_SHA224_MODE_EN
    input  logic               mode224_i,
`endif
    output logic [COUNT_W-1:0] block_cnt_o
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rounds
        $error("sha256_chain_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] RND_LAST = 6'(64 - ROUNDS_PER_CYCLE);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    typedef enum logic [1:0] {eIdle, eBusy, eFold, eDone} state_e;

    state_e               state_q;
    logic [5:0]           rnd_q;
    logic [31:0]          w_q  [16];
    logic [31:0]          wk_q [8];
    logic [31:0]          h_q  [8];
    logic                 chain_q;
    logic                 last_q;
    logic                 mode_q;
    logic                 v_q;
    logic [255:0]         digest_q;
    logic [COUNT_W-1:0]   cnt_q;

    logic [31:0]          work_d [8];
    logic [31:0]          w_d    [16];
    logic [31:0]          blk_w  [16];
    logic [31:0]          h_sum  [8];
    logic [31:0]          iv_sel [8];
    logic [255:0]         digest_d;
    logic                 mode_sel;
    logic                 accept;
    logic                 new_msg;

`ifdef SHA256_SHA224_MODE_EN
    assign mode_sel = mode224_i;
`else
    assign mode_sel = 1'b0;
`endif

    assign ready_o     = (state_q == eIdle) & en_i & reset_n_i;
    assign accept      = v_i & ready_o;
    assign new_msg     = first_i | ~chain_q;
    assign v_o         = v_q;
    assign digest_o    = digest_q;
    assign block_cnt_o = cnt_q;

    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_blk
        assign blk_w[gi] = block_i[511-32*gi -: 32];
    end

    for (gi = 0; gi < 8; gi++) begin : g_fold
        assign h_sum[gi]  = h_q[gi] + wk_q[gi];
        assign iv_sel[gi] = mode_sel ? IV224[gi] : IV256[gi];
        // SHA-224 truncates to H0..H6; the last digest word reads as zero.
        if (gi == 7) begin : g_tail
            assign digest_d[31:0] = mode_q ? 32'h0 : h_sum[gi];
        end else begin : g_word
            assign digest_d[255-32*gi -: 32] = h_sum[gi];
        end
    end

    // Unrolled compression rounds; window slot 0 always holds Wt for the current round.
    always_comb begin
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] wnew;
        work_d = wk_q;
        w_d    = w_q;
        t1     = '0;
        t2     = '0;
        wnew   = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            t1 = work_d[7] + bsig1(work_d[4])
               + ((work_d[4] & work_d[5]) ^ (~work_d[4] & work_d[6]))
               + K_TAB[rnd_q + 6'(j)] + w_d[0];
            t2 = bsig0(work_d[0])
               + ((work_d[0] & work_d[1]) ^ (work_d[0] & work_d[2]) ^ (work_d[1] & work_d[2]));
            work_d[7] = work_d[6];
            work_d[6] = work_d[5];
            work_d[5] = work_d[4];
            work_d[4] = work_d[3] + t1;
            work_d[3] = work_d[2];
            work_d[2] = work_d[1];
            work_d[1] = work_d[0];
            work_d[0] = t1 + t2;
            wnew = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
            for (int k = 0; k < 15; k++) begin
                w_d[k] = w_d[k+1];
            end
            w_d[15] = wnew;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= eIdle;
            rnd_q    <= '0;
            w_q      <= '{default: '0};
            wk_q     <= '{default: '0};
            h_q      <= IV256;
            chain_q  <= 1'b0;
            last_q   <= 1'b0;
            mode_q   <= 1'b0;
            v_q      <= 1'b0;
            digest_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                eIdle: begin
                    if (accept) begin
                        state_q <= eBusy;
                        rnd_q   <= '0;
                        w_q     <= blk_w;
                        last_q  <= last_i;
                        if (new_msg) begin
                            h_q    <= iv_sel;
                            wk_q   <= iv_sel;
                            mode_q <= mode_sel;
                            cnt_q  <= COUNT_W'(1);
                        end else begin
                            wk_q <= h_q;
                            if (!(&cnt_q)) begin
                                cnt_q <= cnt_q + COUNT_W'(1);
                            end
                        end
                    end
                end
                eBusy: begin
                    if (en_i) begin
                        wk_q  <= work_d;
                        w_q   <= w_d;
                        rnd_q <= rnd_q + RND_STEP;
                        if (rnd_q == RND_LAST) begin
                            state_q <= eFold;
                        end
                    end
                end
                eFold: begin
                    if (en_i) begin
                        h_q <= h_sum;
                        if (last_q) begin
                            digest_q <= digest_d;
                            v_q      <= 1'b1;
                            chain_q  <= 1'b0;
                            state_q  <= eDone;
                        end else begin
                            chain_q <= 1'b1;
                            state_q <= eIdle;
                        end
                    end
                end
                eDone: begin
                    // The output handshake is honoured even while the core is disabled.
                    if (yumi_i) begin
                        v_q     <= 1'b0;
                        state_q <= eIdle;
                    end
                end
                default: state_q <= eIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_chain_core.sv
// Directed bench for sha256_chain_core: one instance with 1 round/cycle, one with
// 8 rounds/cycle and a 2-bit block counter to reach counter saturation.
module tb_sha256_chain_core;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] ABC224_DIG =
        256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         first = 1'b0;
    logic         last = 1'b0;
    logic         mode = 1'b0;
    logic [511:0] blk = '0;
    logic         v1 = 1'b0, y1 = 1'b0, v8 = 1'b0, y8 = 1'b0;
    logic         r1, vo1, r8, vo8;
    logic [255:0] d1, d8;
    logic [15:0]  c1;
    logic [1:0]   c8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_chain_core #(.ROUNDS_PER_CYCLE(1), .COUNT_W(16)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .v_i(v1), .ready_o(r1),
        .block_i(blk), .first_i(first), .last_i(last), .v_o(vo1), .yumi_i(y1),
        .digest_o(d1),
`ifdef SHA256_SHA224_MODE_EN
        .mode224_i(mode),
`endif
        .block_cnt_o(c1));

    sha256_chain_core #(.ROUNDS_PER_CYCLE(8), .COUNT_W(2)) dut8 (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .v_i(v8), .ready_o(r8),
        .block_i(blk), .first_i(first), .last_i(last), .v_o(vo8), .yumi_i(y8),
        .digest_o(d8),
`ifdef SHA256_SHA224_MODE_EN
        .mode224_i(1'b0),
`endif
        .block_cnt_o(c8));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds v_i high until the core accepts; reports whether a digest appeared meanwhile.
    task automatic send(input bit sel, input logic [511:0] b, input logic f, input logic l,
                        output bit saw_v);
        int n;
        saw_v = 1'b0;
        n = 0;
        blk = b;
        first = f;
        last = l;
        if (sel) v8 = 1'b1; else v1 = 1'b1;
        while (!(sel ? r8 : r1) && n < 300) begin
            tick();
            n++;
            if (sel ? vo8 : vo1) saw_v = 1'b1;
        end
        chk("send_ready", {255'b0, (sel ? r8 : r1)}, 256'd1);
        tick();
        v1 = 1'b0;
        v8 = 1'b0;
        $display("tx: dut%0d block accepted first=%0b last=%0b", sel ? 8 : 1, f, l);
    endtask

    task automatic wait_v(input bit sel, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(sel ? vo8 : vo1) && lat < 300);
    endtask

    task automatic pop(input bit sel);
        if (sel) y8 = 1'b1; else y1 = 1'b1;
        tick();
        y1 = 1'b0;
        y8 = 1'b0;
    endtask

    initial begin
        int lat;
        int dis;
        int seen;
        bit sv;
        logic [255:0] held;

        // Reset state
        tick();
        tick();
        chk("rst_ready1", {255'b0, r1}, 256'd0);
        chk("rst_ready8", {255'b0, r8}, 256'd0);
        chk("rst_v1", {255'b0, vo1}, 256'd0);
        chk("rst_digest1", d1, 256'd0);
        chk("rst_cnt1", 256'(c1), 256'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready1", {255'b0, r1}, 256'd1);

        // yumi with no digest pending has no effect
        pop(1'b0);
        chk("idle_yumi_v", {255'b0, vo1}, 256'd0);
        chk("idle_yumi_ready", {255'b0, r1}, 256'd1);

        // "abc", single block, 1 round/cycle
        send(1'b0, ABC_BLK, 1'b1, 1'b1, sv);
        chk("abc_cnt", 256'(c1), 256'd1);
        wait_v(1'b0, lat);
        chk("abc_latency", 256'(lat), 256'd65);
        chk("abc_digest", d1, ABC_DIG);
        $display("tx: abc digest=%h latency=%0d", d1, lat);

        // Disabled core keeps v_o up and still honours yumi
        en = 1'b0;
        tick(); tick(); tick();
        chk("dis_hold_v", {255'b0, vo1}, 256'd1);
        pop(1'b0);
        chk("dis_yumi_v", {255'b0, vo1}, 256'd0);
        chk("dis_ready", {255'b0, r1}, 256'd0);
        en = 1'b1;
        #1;
        chk("en_ready", {255'b0, r1}, 256'd1);
        chk("digest_retained", d1, ABC_DIG);

        // first_i=0 with no open chain is a fresh message
        send(1'b0, ABC_BLK, 1'b0, 1'b1, sv);
        chk("nofirst_cnt", 256'(c1), 256'd1);
        wait_v(1'b0, lat);
        chk("nofirst_digest", d1, ABC_DIG);
        $display("tx: abc (first=0) digest=%h", d1);
        pop(1'b0);

        // Two-block message; second block is offered while the core is busy
        send(1'b0, TWO_BLK1, 1'b1, 1'b0, sv);
        send(1'b0, TWO_BLK2, 1'b0, 1'b1, sv);
        chk("two_no_early_v", {255'b0, sv}, 256'd0);
        chk("two_cnt", 256'(c1), 256'd2);
        wait_v(1'b0, lat);
        chk("two_latency", 256'(lat), 256'd65);
        chk("two_digest", d1, TWO_DIG);
        $display("tx: two-block digest=%h", d1);
        pop(1'b0);

        // en_i toggled while hashing "abc"
        send(1'b0, ABC_BLK, 1'b1, 1'b1, sv);
        lat = 0;
        dis = 0;
        while (!vo1 && lat < 400) begin
            en = ($urandom_range(0, 3) != 0);
            if (!en) dis++;
            tick();
            lat++;
        end
        en = 1'b1;
        chk("entog_latency", 256'(lat), 256'(65 + dis));
        chk("entog_digest", d1, ABC_DIG);
        $display("tx: en-toggled abc latency=%0d disabled=%0d", lat, dis);
        pop(1'b0);

        // 8 rounds/cycle, consumer stalls for 20 cycles
        send(1'b1, ABC_BLK, 1'b1, 1'b1, sv);
        wait_v(1'b1, lat);
        chk("r8_latency", 256'(lat), 256'd9);
        chk("r8_digest", d8, ABC_DIG);
        held = d8;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("r8_hold_v", {255'b0, vo8}, 256'd1);
            chk("r8_hold_ready", {255'b0, r8}, 256'd0);
            chk("r8_hold_digest", d8, held);
        end
        pop(1'b1);
        chk("r8_pop_v", {255'b0, vo8}, 256'd0);
        chk("r8_pop_ready", {255'b0, r8}, 256'd1);
        chk("r8_pop_digest", d8, ABC_DIG);
        $display("tx: r8 abc digest=%h latency=%0d", d8, lat);

        // Block counter saturation (2-bit), then first_i restarts an open chain
        send(1'b1, ABC_BLK, 1'b1, 1'b0, sv);
        chk("sat_cnt1", 256'(c8), 256'd1);
        send(1'b1, ABC_BLK, 1'b0, 1'b0, sv);
        chk("sat_cnt2", 256'(c8), 256'd2);
        send(1'b1, ABC_BLK, 1'b0, 1'b0, sv);
        chk("sat_cnt3", 256'(c8), 256'd3);
        send(1'b1, ABC_BLK, 1'b0, 1'b0, sv);
        chk("sat_cnt_hold", 256'(c8), 256'd3);
        send(1'b1, ABC_BLK, 1'b1, 1'b1, sv);
        chk("restart_no_v", {255'b0, sv}, 256'd0);
        chk("restart_cnt", 256'(c8), 256'd1);
        wait_v(1'b1, lat);
        chk("restart_digest", d8, ABC_DIG);
        $display("tx: restarted chain digest=%h", d8);
        pop(1'b1);

`ifdef SHA256_SHA224_MODE_EN
        mode = 1'b1;
        send(1'b0, ABC_BLK, 1'b1, 1'b1, sv);
        mode = 1'b0;
        wait_v(1'b0, lat);
        chk("sha224_digest", d1, ABC224_DIG);
        $display("tx: sha224 abc digest=%h", d1);
        pop(1'b0);
`endif

        // Reset mid-hash aborts without a digest
        send(1'b0, ABC_BLK, 1'b1, 1'b1, sv);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_v", {255'b0, vo1}, 256'd0);
        chk("abort_ready", {255'b0, r1}, 256'd0);
        chk("abort_cnt", 256'(c1), 256'd0);
        chk("abort_digest", d1, 256'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_rel_ready", {255'b0, r1}, 256'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (vo1) seen++;
        end
        chk("abort_no_digest", 256'(seen), 256'd0);
        $display("tx: mid-hash reset, digests seen=%0d", seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
